// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB-first, optional parity, stop bit.
// Each bit lasts max(prescale,1) clk cycles; all frame settings are latched at accept.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [5:0]            prescale,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_n;
  logic [5:0]            edge_cnt, edge_n;
  logic [5:0]            p_last, p_last_n;
  logic [BW-1:0]         bit_cnt, bit_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  par_en_q, par_en_n;
  logic                  par_bit, par_bit_n;
  logic                  tx_n, busy_n;
  logic                  bit_end;

  // p_last holds P-1, so prescale values 0 and 1 both yield one-cycle bits
  assign bit_end = (edge_cnt == p_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      p_last   <= '0;
      shreg    <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      edge_cnt <= edge_n;
      bit_cnt  <= bit_n;
      p_last   <= p_last_n;
      shreg    <= shreg_n;
      par_en_q <= par_en_n;
      par_bit  <= par_bit_n;
      tx_out   <= tx_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    edge_n    = bit_end ? 6'd0 : edge_cnt + 6'd1;
    bit_n     = bit_cnt;
    p_last_n  = p_last;
    shreg_n   = shreg;
    par_en_n  = par_en_q;
    par_bit_n = par_bit;
    tx_n      = tx_out;
    busy_n    = busy;
    unique case (state)
      IDLE: begin
        edge_n = '0;
        bit_n  = '0;
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (data_valid) begin
          state_n   = START;
          shreg_n   = p_data;
          par_en_n  = par_en;
          par_bit_n = par_typ ? ~^p_data : ^p_data;
          p_last_n  = (prescale > 6'd1) ? prescale - 6'd1 : 6'd0;
          tx_n      = 1'b0;
          busy_n    = 1'b1;
        end
      end
      START: if (bit_end) begin
        state_n = DATA;
        tx_n    = shreg[0];
      end
      DATA: if (bit_end) begin
        if (bit_cnt == LAST_BIT) begin
          bit_n   = '0;
          state_n = par_en_q ? PARITY : STOP;
          tx_n    = par_en_q ? par_bit : 1'b1;
        end else begin
          // shift so the next data bit always sits at shreg[1] -> shreg[0]
          bit_n   = bit_cnt + 1'b1;
          shreg_n = shreg >> 1;
          tx_n    = shreg[1];
        end
      end
      PARITY: if (bit_end) begin
        state_n = STOP;
        tx_n    = 1'b1;
      end
      STOP: if (bit_end) begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
